// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - writeback stage: EX/load merge, pending-load FIFO, load alignment
module wb_stage #(
  parameter int LD_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        ex_valid_i,
  output logic        ex_ready_o,
  input  logic        ex_we_i,
  input  logic [4:0]  ex_rd_i,
  input  logic [31:0] ex_wdata_i,
  input  logic        ld_issue_i,
  input  logic [4:0]  ld_rd_i,
  input  logic [2:0]  ld_type_i,
  input  logic [1:0]  ld_offset_i,
  output logic        ld_full_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        rf_we_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o,
  output logic [31:0] pend_mask_o,
  output logic        ld_err_o
);

  localparam int PW = (LD_DEPTH > 1) ? $clog2(LD_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(LD_DEPTH);

  typedef struct packed {
    logic [4:0] rd;
    logic [2:0] typ;
    logic [1:0] off;
  } ld_ent_t;

  ld_ent_t       ent_q [LD_DEPTH];
  ld_ent_t       ent_d [LD_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rf_we_q, rf_we_d;
  logic [4:0]    rf_waddr_q, rf_waddr_d;
  logic [31:0]   rf_wdata_q, rf_wdata_d;
  logic          ld_err_q, ld_err_d;

  logic          fifo_empty, fifo_full, pop_ok, push_ok, push_err, pop_err;
  ld_ent_t       head;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   ld_data;
  logic [31:0]   mask;

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == FULL_CNT);
  assign pop_ok     = mem_rvalid_i && !fifo_empty;
  assign pop_err    = mem_rvalid_i && fifo_empty;
  // A pop in the same cycle frees the slot, so a push while full still lands.
  assign push_ok    = ld_issue_i && (!fifo_full || pop_ok);
  assign push_err   = ld_issue_i && fifo_full && !pop_ok;
  assign ex_ready_o = ~mem_rvalid_i;
  assign head       = ent_q[rd_ptr_q];

  always_comb begin
    byte_sel = mem_rdata_i[7:0];
    case (head.off)
      2'd0: byte_sel = mem_rdata_i[7:0];
      2'd1: byte_sel = mem_rdata_i[15:8];
      2'd2: byte_sel = mem_rdata_i[23:16];
      2'd3: byte_sel = mem_rdata_i[31:24];
      default: byte_sel = mem_rdata_i[7:0];
    endcase
    half_sel = head.off[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    case (head.typ)
      3'b000:  ld_data = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  ld_data = {24'h0, byte_sel};
      3'b001:  ld_data = {{16{half_sel[15]}}, half_sel};
      3'b101:  ld_data = {16'h0, half_sel};
      default: ld_data = mem_rdata_i;
    endcase
  end

  always_comb begin
    ent_d    = ent_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      ent_d[wr_ptr_q] = '{rd: ld_rd_i, typ: ld_type_i, off: ld_offset_i};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    cnt_d    = cnt_q + CW'(push_ok) - CW'(pop_ok);
    ld_err_d = ld_err_q | push_err | pop_err;
  end

  // Load response wins over EX; address/data hold when nothing writes.
  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (pop_ok) begin
      rf_we_d    = (head.rd != 5'd0);
      rf_waddr_d = head.rd;
      rf_wdata_d = ld_data;
    end else if (ex_valid_i && ex_ready_o) begin
      rf_we_d    = ex_we_i && (ex_rd_i != 5'd0);
      rf_waddr_d = ex_rd_i;
      rf_wdata_d = ex_wdata_i;
    end
  end

  always_comb begin
    mask = '0;
    for (int k = 0; k < LD_DEPTH; k++) begin
      if (CW'(k) < cnt_q) begin
        mask[ent_q[rd_ptr_q + PW'(k)].rd] = 1'b1;
      end
    end
    mask[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < LD_DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      ld_err_q   <= 1'b0;
    end else begin
      ent_q      <= ent_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      ld_err_q   <= ld_err_d;
    end
  end

  assign rf_we_o     = rf_we_q;
  assign rf_waddr_o  = rf_waddr_q;
  assign rf_wdata_o  = rf_wdata_q;
  assign pend_mask_o = mask;
  assign ld_full_o   = fifo_full;
  assign ld_err_o    = ld_err_q;

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - self-checking bench for wb_stage with queue-based reference model
module tb_wb_stage;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        ex_valid_i, ex_we_i, ld_issue_i, mem_rvalid_i;
  logic [4:0]  ex_rd_i, ld_rd_i;
  logic [31:0] ex_wdata_i, mem_rdata_i;
  logic [2:0]  ld_type_i;
  logic [1:0]  ld_offset_i;
  logic        ex_ready_o, ld_full_o, rf_we_o, ld_err_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o, pend_mask_o;

  always #5 clk = ~clk;

  wb_stage #(.LD_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o), .ex_we_i(ex_we_i),
    .ex_rd_i(ex_rd_i), .ex_wdata_i(ex_wdata_i),
    .ld_issue_i(ld_issue_i), .ld_rd_i(ld_rd_i), .ld_type_i(ld_type_i),
    .ld_offset_i(ld_offset_i), .ld_full_o(ld_full_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .pend_mask_o(pend_mask_o), .ld_err_o(ld_err_o)
  );

  typedef struct {
    logic [4:0] rd;
    logic [2:0] t;
    logic [1:0] off;
  } mentry_t;

  mentry_t     mq[$];
  logic        m_err, m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  int          n_pass = 0;
  int          n_total = 0;

  function automatic logic [31:0] ref_ext(input logic [2:0] t, input logic [1:0] off,
                                          input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * int'(off))) & 32'hFF;
    h = (w >> (16 * (int'(off) / 2))) & 32'hFFFF;
    case (t)
      3'd0:    return (b >= 32'd128) ? b - 32'd256 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] ref_mask();
    logic [31:0] m;
    m = '0;
    foreach (mq[i]) m[mq[i].rd] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

  task automatic idle_inputs();
    ex_valid_i = 0; ex_we_i = 0; ex_rd_i = 0; ex_wdata_i = 0;
    ld_issue_i = 0; ld_rd_i = 0; ld_type_i = 0; ld_offset_i = 0;
    mem_rvalid_i = 0; mem_rdata_i = 0;
  endtask

  task automatic model_reset();
    mq.delete();
    m_err = 0; m_we = 0; m_waddr = 0; m_wdata = 0;
  endtask

  // Advances the model by one accepting edge, then steps the DUT to just after that edge.
  task automatic drive_cycle();
    mentry_t h;
    bit      popped;
    int      n0;
    n0 = mq.size();
    popped = 0;
    m_we = 0;
    if (mem_rvalid_i) begin
      if (n0 == 0) m_err = 1;
      else begin h = mq.pop_front(); popped = 1; end
    end
    if (ld_issue_i) begin
      if (n0 == DEPTH && !popped) m_err = 1;
      else mq.push_back('{rd: ld_rd_i, t: ld_type_i, off: ld_offset_i});
    end
    if (popped) begin
      m_we = (h.rd != 0); m_waddr = h.rd; m_wdata = ref_ext(h.t, h.off, mem_rdata_i);
    end else if (ex_valid_i && !mem_rvalid_i) begin
      m_we = ex_we_i && (ex_rd_i != 0); m_waddr = ex_rd_i; m_wdata = ex_wdata_i;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_ni = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst_ni = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [2:0] t, input logic [1:0] off);
    idle_inputs();
    ld_issue_i = 1; ld_rd_i = rd; ld_type_i = t; ld_offset_i = off;
    drive_cycle();
  endtask

  task automatic respond(input logic [31:0] data);
    idle_inputs();
    mem_rvalid_i = 1; mem_rdata_i = data;
    drive_cycle();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_ni = 0;
    #2;
    n_total++;
    if ({rf_we_o, rf_waddr_o, rf_wdata_o} !== 38'h0)
      $display("FAIL reset_rf got we=%b a=%0d d=%h need 0", rf_we_o, rf_waddr_o, rf_wdata_o);
    else n_pass++;
    n_total++;
    if ({pend_mask_o, ld_full_o, ld_err_o, ex_ready_o} !== {32'h0, 3'b001})
      $display("FAIL reset_state got mask=%h full=%b err=%b rdy=%b", pend_mask_o, ld_full_o, ld_err_o, ex_ready_o);
    else n_pass++;
    apply_reset();
  endtask

  task automatic test_ex_write();
    idle_inputs();
    ex_valid_i = 1; ex_we_i = 1; ex_rd_i = 5; ex_wdata_i = 32'h1234_5678;
    drive_cycle();
    n_total++;
    if ({rf_we_o, rf_waddr_o, rf_wdata_o} !== {1'b1, 5'd5, 32'h1234_5678})
      $display("FAIL ex_write got we=%b a=%0d d=%h need 1/5/12345678", rf_we_o, rf_waddr_o, rf_wdata_o);
    else n_pass++;
    idle_inputs();
    drive_cycle();
    n_total++;
    if (rf_we_o !== 1'b0) $display("FAIL ex_we_clear got %b need 0", rf_we_o);
    else n_pass++;
  endtask

  task automatic test_load_ext();
    logic [2:0]  tt[3]   = '{3'b000, 3'b100, 3'b101};
    logic [1:0]  oo[3]   = '{2'd2, 2'd2, 2'd3};
    logic [31:0] dd[3]   = '{32'h0080_0000, 32'h0080_0000, 32'hBEEF_0000};
    logic [31:0] want[3] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_BEEF};
    for (int i = 0; i < 3; i++) begin
      issue(5'd3, tt[i], oo[i]);
      n_total++;
      if (pend_mask_o !== 32'h8) $display("FAIL ext_mask%0d got %h need 00000008", i, pend_mask_o);
      else n_pass++;
      respond(dd[i]);
      n_total++;
      if ({rf_we_o, rf_waddr_o, rf_wdata_o} !== {1'b1, 5'd3, want[i]})
        $display("FAIL ext%0d got we=%b a=%0d d=%h need 1/3/%h", i, rf_we_o, rf_waddr_o, rf_wdata_o, want[i]);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    issue(5'd7, 3'b010, 2'd0);
    issue(5'd9, 3'b010, 2'd0);
    n_total++;
    if ({ld_full_o, pend_mask_o} !== {1'b1, 32'h0000_0280})
      $display("FAIL b2b_full got full=%b mask=%h need 1/00000280", ld_full_o, pend_mask_o);
    else n_pass++;
    idle_inputs();
    ex_valid_i = 1; ex_we_i = 1; ex_rd_i = 12; ex_wdata_i = 32'hCAFE_0012;
    mem_rvalid_i = 1; mem_rdata_i = 32'hAAAA_0007;
    #1;
    n_total++;
    if (ex_ready_o !== 1'b0) $display("FAIL b2b_rdy1 got %b need 0", ex_ready_o);
    else n_pass++;
    drive_cycle();
    n_total++;
    if ({rf_we_o, rf_waddr_o, rf_wdata_o, pend_mask_o} !== {1'b1, 5'd7, 32'hAAAA_0007, 32'h200})
      $display("FAIL b2b_x7 got we=%b a=%0d d=%h m=%h", rf_we_o, rf_waddr_o, rf_wdata_o, pend_mask_o);
    else n_pass++;
    mem_rdata_i = 32'hBBBB_0009;
    #1;
    n_total++;
    if (ex_ready_o !== 1'b0) $display("FAIL b2b_rdy2 got %b need 0", ex_ready_o);
    else n_pass++;
    drive_cycle();
    n_total++;
    if ({rf_we_o, rf_waddr_o, rf_wdata_o, pend_mask_o} !== {1'b1, 5'd9, 32'hBBBB_0009, 32'h0})
      $display("FAIL b2b_x9 got we=%b a=%0d d=%h m=%h", rf_we_o, rf_waddr_o, rf_wdata_o, pend_mask_o);
    else n_pass++;
    mem_rvalid_i = 0;
    drive_cycle();
    n_total++;
    if ({rf_we_o, rf_waddr_o, rf_wdata_o} !== {1'b1, 5'd12, 32'hCAFE_0012})
      $display("FAIL b2b_ex got we=%b a=%0d d=%h need 1/12/cafe0012", rf_we_o, rf_waddr_o, rf_wdata_o);
    else n_pass++;
    idle_inputs();
  endtask

  task automatic test_full_overflow();
    apply_reset();
    issue(5'd10, 3'b010, 2'd0);
    issue(5'd11, 3'b010, 2'd0);
    idle_inputs();
    ld_issue_i = 1; ld_rd_i = 12; ld_type_i = 3'b010;
    mem_rvalid_i = 1; mem_rdata_i = 32'h0000_000A;
    drive_cycle();
    n_total++;
    if ({ld_full_o, ld_err_o, pend_mask_o, rf_waddr_o} !== {2'b10, 32'h1800, 5'd10})
      $display("FAIL full_swap got full=%b err=%b m=%h a=%0d", ld_full_o, ld_err_o, pend_mask_o, rf_waddr_o);
    else n_pass++;
    issue(5'd13, 3'b010, 2'd0);
    n_total++;
    if ({ld_full_o, ld_err_o, pend_mask_o} !== {2'b11, 32'h1800})
      $display("FAIL full_drop got full=%b err=%b m=%h need 1/1/00001800", ld_full_o, ld_err_o, pend_mask_o);
    else n_pass++;
    respond(32'h11);
    respond(32'h12);
    n_total++;
    if ({rf_waddr_o, ld_full_o, pend_mask_o} !== {5'd12, 1'b0, 32'h0})
      $display("FAIL full_drain got a=%0d full=%b m=%h need 12/0/0", rf_waddr_o, ld_full_o, pend_mask_o);
    else n_pass++;
  endtask

  task automatic test_empty_pop_rd0();
    apply_reset();
    respond(32'hDEAD_BEEF);
    n_total++;
    if ({rf_we_o, ld_err_o} !== 2'b01) $display("FAIL empty_pop got we=%b err=%b need 0/1", rf_we_o, ld_err_o);
    else n_pass++;
    apply_reset();
    issue(5'd0, 3'b010, 2'd0);
    issue(5'd4, 3'b010, 2'd0);
    respond(32'h5555_0000);
    n_total++;
    if ({rf_we_o, pend_mask_o, ld_err_o} !== {1'b0, 32'h10, 1'b0})
      $display("FAIL rd0_pop got we=%b m=%h err=%b need 0/00000010/0", rf_we_o, pend_mask_o, ld_err_o);
    else n_pass++;
    respond(32'h4444_0004);
    n_total++;
    if ({rf_we_o, rf_waddr_o, pend_mask_o} !== {1'b1, 5'd4, 32'h0})
      $display("FAIL rd0_next got we=%b a=%0d m=%h need 1/4/0", rf_we_o, rf_waddr_o, pend_mask_o);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    issue(5'd20, 3'b010, 2'd0);
    issue(5'd21, 3'b010, 2'd0);
    #2 rst_ni = 0;
    #1;
    n_total++;
    if ({pend_mask_o, ld_full_o, rf_we_o} !== 34'h0)
      $display("FAIL rst_mid got m=%h full=%b we=%b need 0", pend_mask_o, ld_full_o, rf_we_o);
    else n_pass++;
    model_reset();
    @(negedge clk);
    rst_ni = 1;
    respond(32'h1);
    n_total++;
    if ({ld_err_o, rf_we_o} !== 2'b10) $display("FAIL rst_late_resp got err=%b we=%b need 1/0", ld_err_o, rf_we_o);
    else n_pass++;
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      idle_inputs();
      ld_issue_i   = ($urandom_range(0, 9) < 4);
      ld_rd_i      = 5'($urandom);
      ld_type_i    = 3'($urandom);
      ld_offset_i  = 2'($urandom);
      mem_rvalid_i = (mq.size() > 0) ? ($urandom_range(0, 9) < 5) : ($urandom_range(0, 49) == 0);
      mem_rdata_i  = $urandom;
      ex_valid_i   = $urandom_range(0, 1);
      ex_we_i      = ($urandom_range(0, 3) != 0);
      ex_rd_i      = 5'($urandom);
      ex_wdata_i   = $urandom;
      #1;
      n_total++;
      if (ex_ready_o !== !mem_rvalid_i) $display("FAIL rnd_rdy c=%0d got %b", c, ex_ready_o);
      else n_pass++;
      drive_cycle();
      n_total++;
      if (rf_we_o !== m_we || (m_we && (rf_waddr_o !== m_waddr || rf_wdata_o !== m_wdata)))
        $display("FAIL rnd_rf c=%0d got %b/%0d/%h need %b/%0d/%h", c, rf_we_o, rf_waddr_o, rf_wdata_o, m_we, m_waddr, m_wdata);
      else n_pass++;
      n_total++;
      if ({pend_mask_o, ld_full_o, ld_err_o} !== {ref_mask(), mq.size() == DEPTH, m_err})
        $display("FAIL rnd_state c=%0d got m=%h f=%b e=%b need m=%h f=%b e=%b", c, pend_mask_o, ld_full_o, ld_err_o,
                 ref_mask(), mq.size() == DEPTH, m_err);
      else n_pass++;
    end
    idle_inputs();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_ex_write();
    test_load_ext();
    test_back_to_back();
    test_full_overflow();
    test_empty_pop_rd0();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
